param_sync_ram: RTL
===================

Name: param_sync_ram

Overview:
Parametrised single-port synchronous RAM. It generalises the team's 4x8 blocking/non-blocking memory experiment in four ways: configurable width and depth, a selectable read-during-write mode, a registered valid flag, and a post-reset clear sequencer. It is used as the standard scratch/buffer memory in clocked datapaths. Only this block writes the array.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 2, address width in bits; DEPTH = 2**ADDR_W words (ADDR_W >= 1)
RDW_MODE, 0, read-during-write result: 0 = read-first (old word, non-blocking semantics), 1 = write-first (new word, blocking semantics)
INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequence

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
en  input  1  access request, qualified by !busy
we  input  1  1 = write, 0 = read; sampled only when en=1 and busy=0
a  input  ADDR_W  word address
d_i  input  DATA_W  write data
d_o  output  DATA_W  registered read data
d_o_valid  output  1  one-cycle pulse: d_o holds the result of an access accepted on the previous edge
busy  output  1  1 while the clear sequence runs; requests are ignored
parity_err  output  1  present only with PARITY_EN (see Optional Feature)

Behaviour:
- Reset and clock: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values, at the edge where rst=1: d_o=0, d_o_valid=0, busy=1, clear counter=0, FSM in CLEAR. Array contents are not reset directly.
- FSM states:
  - CLEAR: each edge with rst=0 writes INIT_VAL to mem[cnt] and increments cnt. On the edge that writes DEPTH-1, go to READY and set busy=0. busy is therefore high for exactly DEPTH edges after rst is released.
  - READY: accepts requests. Stays in READY until rst.
- Accepted access = en=1 and busy=0 at a posedge.
  - Write (we=1): mem[a] <= d_i.
  - Every accepted access, read or write, also loads d_o at the same edge and sets d_o_valid=1. Latency is 1 cycle.
- Read-during-write on an accepted write:
  - RDW_MODE=0: d_o = previous mem[a].
  - RDW_MODE=1: d_o = d_i.
- No accepted access (en=0, or busy=1): d_o holds its last value; d_o_valid=0 on the next edge.
- Back-to-back accesses are allowed every cycle. A read of an address written on the previous edge returns the new data in both modes.
- en/we/a/d_i during busy=1 have no effect on the array or on d_o.
- Reset mid-CLEAR restarts at cnt=0.
- Reset mid-operation: any pending result is dropped (d_o_valid=0, d_o=0) and the full clear re-runs.
- Addresses always fall inside the array (DEPTH = 2**ADDR_W), so there is no out-of-range case.

Optional Feature:
PARAM_SYNC_RAM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit computed from d_i on write; the clear sequence stores parity(INIT_VAL).
  - On every accepted access, parity_err is registered alongside d_o: 1 if the parity recomputed over the returned word mismatches the stored bit.
  - In RDW_MODE=1 writes, parity_err=0.
  - parity_err resets to 0 and is 0 whenever d_o_valid=0.
- Not defined: no parity storage and no parity_err port; the array is exactly DATA_W bits wide.

Test Plan:
1. Default params: pulse rst 1 cycle, then hold en=0 -> busy=1 for exactly 4 edges, then 0; reads of addresses 0..3 return 0 with d_o_valid pulses 1 cycle later.
2. RDW_MODE=0: read a=1 after clear -> d_o=0. Write a=1, d_i=22 -> d_o=0 (old word). Read a=1, d_i=33 -> d_o=22. Read a=1, d_i=44 -> d_o=22.
3. RDW_MODE=1, same sequence -> write returns d_o=22 on the write edge; subsequent reads return 22.
4. Write 0xAA to a=2 while busy=1 (en=1, we=1) -> ignored; after clear, read a=2 returns INIT_VAL. Set INIT_VAL=8'h5A -> all four words read 0x5A.
5. DATA_W=16, ADDR_W=4: write the address value k to each of addresses 0..15 on back-to-back cycles, then read back -> d_o=k each cycle, d_o_valid continuously 1. Assert rst mid-stream -> d_o_valid=0, busy=1 for 16 edges, all words back to 0.
6. PARAM_SYNC_RAM_PARITY_EN defined: write 0x0F to a=3, force-flip bit 0 of mem[3] via hierarchical access, read a=3 -> parity_err=1 with d_o_valid=1; an unflipped word gives parity_err=0.

Source files
------------

// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port synchronous RAM with selectable read-during-write, valid flag and post-reset clear.
// Optional PARAM_SYNC_RAM_PARITY_EN adds a stored even-parity bit per word and a parity_err output.
module param_sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o,
  output logic              d_o_valid,
`ifdef PARAM_SYNC_RAM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARAM_SYNC_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  logic [MEM_W-1:0] mem [DEPTH];
  logic acc, fwd;
  logic [MEM_W-1:0] init_word, wr_word, rd_word;
  assign busy = state == CLEAR;
  assign acc = en && !busy;
  assign fwd = (RDW_MODE == 1) && we;
  assign rd_word = mem[a];
`ifdef PARAM_SYNC_RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign wr_word = {^d_i, d_i};
`else
  assign init_word = INIT_VAL;
  assign wr_word = d_i;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= READY;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) mem[cnt] <= init_word;
      else if (acc && we) mem[a] <= wr_word;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_o <= '0;
      d_o_valid <= 1'b0;
    end else begin
      d_o_valid <= acc;
      if (acc) d_o <= fwd ? d_i : rd_word[DATA_W-1:0];
    end
  end
`ifdef PARAM_SYNC_RAM_PARITY_EN
  // Stored word includes its parity bit, so any odd total means corruption.
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else parity_err <= acc && !fwd && ^rd_word;
  end
`endif
endmodule
